mono_pixel_packer: RTL and testbench
====================================

MONO_PIXEL_PACKER -- requirements
Module: mono_pixel_packer

Interface
REQ-001 Parameter PIX_PER_LINE, default 512: active pixels per Mac SE line; multiple of 8.
REQ-002 Parameter LINES_PER_FRAME, default 342: active lines per Mac SE frame.
REQ-003 Parameter FIFO_DEPTH, default 4: output byte FIFO entries; power of two.
REQ-004 clk  in  1  single clock domain, rising-edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 pix_valid  in  1  pix_in qualifier from color_converter stage.
REQ-007 pix_in  in  1  mono pixel (color_converter mono_out), 1 = set bit.
REQ-008 pix_sof  in  1  qualified by pix_valid; this pixel is first of frame.
REQ-009 pix_sol  in  1  qualified by pix_valid; this pixel is first of line.
REQ-010 out_valid  out  1  out_data holds a packed byte.
REQ-011 out_ready  in  1  downstream accepts byte when out_valid & out_ready.
REQ-012 out_data  out  8  8 pixels, first pixel in bit 7.
REQ-013 out_sol / out_sof  out  1 each  byte is first of line / first of frame.
REQ-014 overflow  out  1  sticky: a byte was dropped on full FIFO.

Function
REQ-015 States WAIT_SOF, ACTIVE, WAIT_SOL; reset enters WAIT_SOF.
REQ-016 WAIT_SOF: pixels without pix_sof ignored; pix_valid & pix_sof -> ACTIVE, line_cnt=0, pix_cnt=0, pixel taken as frame pixel 0.
REQ-017 ACTIVE: each pix_valid shifts pix_in into the shift register MSB-first, pix_cnt++.
REQ-018 Every 8th pixel of a line: byte written to FIFO with out_sol=1 if first byte of line, out_sof=1 if also line 0.
REQ-019 Latency: with FIFO empty, out_valid rises the cycle after the 8th pixel is sampled.
REQ-020 Pixel PIX_PER_LINE of a line: line_cnt++; if line_cnt was LINES_PER_FRAME-1 -> WAIT_SOF, else -> WAIT_SOL.
REQ-021 WAIT_SOL: pixels without pix_sol/pix_sof dropped (overlong line); pix_sol -> ACTIVE, pix_cnt=0, pixel taken.
REQ-022 pix_sol in ACTIVE with pix_cnt not 0 (short line): partial byte written zero-padded in low bits, line_cnt++, new line starts with this pixel; if line_cnt reaches LINES_PER_FRAME -> WAIT_SOF and pixel dropped.
REQ-023 pix_sof in any state restarts frame per REQ-016; any partial byte discarded, not written.
REQ-024 pix_sof and pix_sol together: pix_sof wins.
REQ-025 At most one FIFO write per cycle; REQ-022 padding write and a new byte cannot coincide (new byte needs 8 pixels).
REQ-026 FIFO: write and read in the same cycle allowed at any fill, including full (full + read + write keeps count).
REQ-027 Write when full with no read: byte dropped, overflow set; state/counters advance normally.
REQ-028 out_data/out_sol/out_sof stable while out_valid & !out_ready.
REQ-029 Counters: pix_cnt width clog2(PIX_PER_LINE+1), line_cnt width clog2(LINES_PER_FRAME+1); no wrap within a frame.

Reset
REQ-030 reset_n low asynchronously clears state to WAIT_SOF, counters, shift register, FIFO pointers; out_valid=0, out_data=0, out_sol=0, out_sof=0, overflow=0.
REQ-031 Reset mid-line discards all buffered bytes; first byte after release requires a new pix_sof.
REQ-032 overflow clears only on reset.

Structure
REQ-033 Shared package mac_se_pkg holds MAC_SE_H_ACTIVE=512, MAC_SE_V_ACTIVE=342, packer state enum.
REQ-034 One sub-module: sync_fifo (width 10 = data+sol+sof, depth FIFO_DEPTH).

Verification
REQ-035 sof, then 512 pixels alternating 1,0 with out_ready=1 -> 64 bytes 0xAA, first with out_sof=1,out_sol=1, rest 0.
REQ-036 Full frame 342x512 all ones -> 21888 bytes 0xFF; 342 with out_sol, 1 with out_sof; then WAIT_SOF, extra pixels produce nothing.
REQ-037 Short line: sof, 11 ones, sol -> bytes 0xFF, 0xE0 (padded), next byte out_sol=1,out_sof=0.
REQ-038 out_ready=0, 48 pixels of ones -> 4 bytes held, overflow=1 after 5th, first 4 bytes delivered intact after out_ready=1.
REQ-039 Reset asserted mid-line with 2 bytes queued -> out_valid=0 immediately; pixels without sof after release -> no output.
REQ-040 pix_sof & pix_sol together mid-line with 3 pixels pending -> partial byte discarded, next byte out_sof=1.

Source files
------------

// File: rtl/mac_se_pkg.sv
// Mac SE video constants, packer state encoding and FIFO entry layout.
// Shared by the mono pixel packer and its byte FIFO.
`timescale 1ns/1ps
package mac_se_pkg;

    localparam int MAC_SE_H_ACTIVE = 512;
    localparam int MAC_SE_V_ACTIVE = 342;

    typedef enum logic [1:0] {
        ST_WAIT_SOF,
        ST_ACTIVE,
        ST_WAIT_SOL
    } pack_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       sol;
        logic       sof;
    } pack_entry_t;

    // Left-justify the n newest bits of a partial byte, zero-filling the rest.
    function automatic logic [7:0] pad_byte(
        input logic [7:0] sh,
        input logic [2:0] n
    );
        logic [3:0] s;
        s = 4'd8 - {1'b0, n};
        return sh << s;
    endfunction

endpackage

// File: rtl/mono_pixel_packer_if.sv
// Pixel-in / byte-out stream bundle for the mono pixel packer.
// The slave modport is the packer; the master drives pixels and accepts bytes.
`timescale 1ns/1ps
interface mono_pixel_packer_if;

    logic       pix_valid;
    logic       pix_in;
    logic       pix_sof;
    logic       pix_sol;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sol;
    logic       out_sof;

    modport slave (
        input  pix_valid, pix_in, pix_sof, pix_sol,
        input  out_ready,
        output out_valid, out_data, out_sol, out_sof
    );

    modport master (
        output pix_valid, pix_in, pix_sof, pix_sol,
        output out_ready,
        input  out_valid, out_data, out_sol, out_sof
    );

endinterface

// File: rtl/mono_pixel_packer_fifo.sv
// Small synchronous FIFO; a write on a full FIFO succeeds only alongside a read.
// Read data is forced to zero while empty so the output bus idles clean.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_wr, do_rd;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_rd   = rd_en_i && !empty_o;
    assign do_wr   = wr_en_i && (!full_o || do_rd);

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (do_wr && !do_rd) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (do_rd && !do_wr) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/mono_pixel_packer.sv
// Packs a 1-bit pixel stream into MSB-first bytes tagged with line/frame start.
// Framing follows pix_sof/pix_sol; short lines are padded, long lines trimmed.
`timescale 1ns/1ps
module mono_pixel_packer
    import mac_se_pkg::*;
#(
    parameter int PIX_PER_LINE    = MAC_SE_H_ACTIVE,
    parameter int LINES_PER_FRAME = MAC_SE_V_ACTIVE,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    mono_pixel_packer_if.slave  bus,
    output logic                overflow
);

    localparam int PW = $clog2(PIX_PER_LINE + 1);
    localparam int LW = $clog2(LINES_PER_FRAME + 1);
    localparam logic [PW-1:0] PPL    = PW'(PIX_PER_LINE);
    localparam logic [PW-1:0] BYTE1  = PW'(8);
    localparam logic [LW-1:0] LPF    = LW'(LINES_PER_FRAME);
    localparam logic [LW-1:0] LPF_M1 = LW'(LINES_PER_FRAME - 1);

    pack_state_e     state_q, state_d;
    logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [LW-1:0]   line_cnt_q, line_cnt_d;
    logic [7:0]      sh_q, sh_d;
    logic            overflow_q;

    logic            wr_en;
    pack_entry_t     wr_ent;
    pack_entry_t     rd_ent;
    logic            fifo_full, fifo_empty;

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        sh_d       = sh_q;
        wr_en      = 1'b0;
        wr_ent     = '0;
        if (bus.pix_valid) begin
            if (bus.pix_sof) begin
                state_d    = ST_ACTIVE;
                line_cnt_d = '0;
                pix_cnt_d  = PW'(1);
                sh_d       = {7'b0, bus.pix_in};
            end else begin
                unique case (state_q)
                    ST_WAIT_SOF: begin
                    end
                    ST_WAIT_SOL: begin
                        if (bus.pix_sol) begin
                            state_d   = ST_ACTIVE;
                            pix_cnt_d = PW'(1);
                            sh_d      = {7'b0, bus.pix_in};
                        end
                    end
                    ST_ACTIVE: begin
                        if (bus.pix_sol) begin
                            // Short line: flush what is pending, then restart.
                            if (pix_cnt_q[2:0] != 3'd0) begin
                                wr_en       = 1'b1;
                                wr_ent.data = pad_byte(sh_q, pix_cnt_q[2:0]);
                                wr_ent.sol  = (pix_cnt_q < BYTE1);
                                wr_ent.sof  = wr_ent.sol && (line_cnt_q == '0);
                            end
                            line_cnt_d = line_cnt_q + LW'(1);
                            if (line_cnt_d == LPF) begin
                                state_d = ST_WAIT_SOF;
                            end else begin
                                pix_cnt_d = PW'(1);
                                sh_d      = {7'b0, bus.pix_in};
                            end
                        end else begin
                            sh_d      = {sh_q[6:0], bus.pix_in};
                            pix_cnt_d = pix_cnt_q + PW'(1);
                            if (pix_cnt_d[2:0] == 3'd0) begin
                                wr_en       = 1'b1;
                                wr_ent.data = sh_d;
                                wr_ent.sol  = (pix_cnt_d == BYTE1);
                                wr_ent.sof  = wr_ent.sol && (line_cnt_q == '0);
                            end
                            if (pix_cnt_d == PPL) begin
                                line_cnt_d = line_cnt_q + LW'(1);
                                state_d    = (line_cnt_q == LPF_M1) ?
                                             ST_WAIT_SOF : ST_WAIT_SOL;
                            end
                        end
                    end
                    default: state_d = ST_WAIT_SOF;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_WAIT_SOF;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            sh_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            sh_q       <= sh_d;
            if (wr_en && fifo_full && !bus.out_ready) overflow_q <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(pack_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_ent),
        .rd_en_i   (bus.out_ready),
        .rd_data_o (rd_ent),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = rd_ent.data;
    assign bus.out_sol   = rd_ent.sol;
    assign bus.out_sof   = rd_ent.sof;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_mono_pixel_packer.sv
// Scoreboard bench for mono_pixel_packer (full 512-pixel lines, short frame).
// Expected bytes are queued as pixels are driven and popped on each handshake.
`timescale 1ns/1ps
module tb_mono_pixel_packer;
    import mac_se_pkg::*;

    localparam int PPL   = 512;
    localparam int LINES = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic overflow;
    bit   rnd_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    pack_entry_t exp_q[$];

    mono_pixel_packer_if bus();

    mono_pixel_packer #(
        .PIX_PER_LINE    (PPL),
        .LINES_PER_FRAME (LINES),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        pack_entry_t e;
        if (reset_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                if (bus.out_ready) check("spurious", bus.out_valid, 1'b0);
            end else if (bus.out_ready) begin
                e = exp_q.pop_front();
                check("data", bus.out_data, e.data);
                check("sol", bus.out_sol, e.sol);
                check("sof", bus.out_sof, e.sof);
            end else begin
                e = exp_q[0];
                check("hold_data", bus.out_data, e.data);
            end
        end
    end

    task automatic push(input logic [7:0] d, input logic sol,
                        input logic sof);
        pack_entry_t e;
        e.data = d;
        e.sol  = sol;
        e.sof  = sof;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic p, input logic sof, input logic sol);
        @(posedge clk);
        #2;
        bus.pix_valid = 1'b1;
        bus.pix_in    = p;
        bus.pix_sof   = sof;
        bus.pix_sol   = sol;
        if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            bus.pix_valid = 1'b0;
            bus.pix_sof   = 1'b0;
            bus.pix_sol   = 1'b0;
            if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #2;
        bus.pix_valid = 1'b0;
        bus.out_ready = r;
    endtask

    task automatic send_ones(input int n, input logic sof,
                             input logic sol);
        drive(1'b1, sof, sol);
        for (int i = 1; i < n; i++) drive(1'b1, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        idle(6);
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        logic       p;
        bus.pix_valid = 1'b0;
        bus.pix_in    = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_sol   = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_data", bus.out_data, 8'h00);
        check("rst_sol", bus.out_sol, 1'b0);
        check("rst_sof", bus.out_sof, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        #1 reset_n = 1'b1;
        idle(2);

        // alternating pixels over one full line
        for (int i = 0; i < PPL / 8; i++) push(8'hAA, i == 0, i == 0);
        for (int i = 0; i < PPL; i++) drive(1'((i + 1) % 2), i == 0, 1'b0);
        idle(1);
        drain();

        // whole frame of ones, then stray pixels after the last line
        for (int l = 0; l < LINES; l++)
            for (int i = 0; i < PPL / 8; i++)
                push(8'hFF, i == 0, (i == 0) && (l == 0));
        for (int l = 0; l < LINES; l++) send_ones(PPL, l == 0, l != 0);
        send_ones(16, 1'b0, 1'b1);
        idle(1);
        drain();

        // short line padding
        push(8'hFF, 1'b1, 1'b1);
        push(8'hE0, 1'b0, 1'b0);
        push(8'hFF, 1'b1, 1'b0);
        send_ones(11, 1'b1, 1'b0);
        send_ones(8, 1'b0, 1'b1);
        idle(1);
        drain();

        // sof+sol mid-line discards the pending partial byte
        push(8'hFF, 1'b1, 1'b1);
        push(8'h81, 1'b1, 1'b1);
        send_ones(11, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        idle(1);
        drain();

        // stalled output: four bytes held, fifth and sixth dropped
        set_ready(1'b0);
        for (int i = 0; i < 4; i++) push(8'hFF, i == 0, i == 0);
        send_ones(32, 1'b1, 1'b0);
        idle(3);
        check("ovf_at_full", overflow, 1'b0);
        check("held_valid", bus.out_valid, 1'b1);
        send_ones(16, 1'b0, 1'b0);
        idle(3);
        check("ovf_set", overflow, 1'b1);
        set_ready(1'b1);
        drain();
        check("ovf_sticky", overflow, 1'b1);

        // async reset with two bytes queued
        set_ready(1'b0);
        send_ones(16, 1'b1, 1'b0);
        idle(3);
        check("pre_rst_valid", bus.out_valid, 1'b1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("midrst_valid", bus.out_valid, 1'b0);
        check("midrst_data", bus.out_data, 8'h00);
        check("midrst_ovf", overflow, 1'b0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        set_ready(1'b1);
        send_ones(24, 1'b0, 1'b0);
        send_ones(8, 1'b0, 1'b1);
        idle(20);
        check("post_rst_quiet", bus.out_valid, 1'b0);
        push(8'hFF, 1'b1, 1'b1);
        send_ones(8, 1'b1, 1'b0);
        idle(1);
        drain();

        // random pixels with random backpressure
        rnd_ready = 1'b1;
        b = 8'h00;
        for (int i = 0; i < 64; i++) begin
            p = 1'($urandom_range(0, 1));
            b = {b[6:0], p};
            if (i % 8 == 7) push(b, i == 7, i == 7);
            drive(p, i == 0, 1'b0);
        end
        idle(4);
        rnd_ready = 1'b0;
        set_ready(1'b1);
        drain();
        check("final_ovf", overflow, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
